// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - instruction IDs, FSM states, forward codes and decode helper
// Ports: none (package). Shared by pipe_hazard_ctrl and its scoreboard.
package pipe_hazard_ctrl_pkg;

  localparam int InstIDDepth = 8;
  localparam int RegAddrW    = 5;

  // Decoder instruction IDs; anything else is treated as a NOP.
  localparam logic [InstIDDepth-1:0] ID_NOP  = InstIDDepth'(0);
  localparam logic [InstIDDepth-1:0] ID_ADDI = InstIDDepth'(1);
  localparam logic [InstIDDepth-1:0] ID_ADD  = InstIDDepth'(2);
  localparam logic [InstIDDepth-1:0] ID_LUI  = InstIDDepth'(3);
  localparam logic [InstIDDepth-1:0] ID_BNE  = InstIDDepth'(4);
  localparam logic [InstIDDepth-1:0] ID_JAL  = InstIDDepth'(5);
  localparam logic [InstIDDepth-1:0] ID_LW   = InstIDDepth'(6);
  localparam logic [InstIDDepth-1:0] ID_SW   = InstIDDepth'(7);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_REDIRECT   = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic                vld;
    logic [RegAddrW-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wr_rd;
    logic is_load;
  } dec_t;

  function automatic dec_t decode(input logic [InstIDDepth-1:0] id);
    dec_t d;
    d = '0;
    case (id)
      ID_ADDI: begin d.use_rs1 = 1'b1; d.wr_rd = 1'b1; end
      ID_ADD:  begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.wr_rd = 1'b1; end
      ID_LUI:  d.wr_rd = 1'b1;
      ID_BNE:  begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      ID_JAL:  d.wr_rd = 1'b1;
      ID_LW:   begin d.use_rs1 = 1'b1; d.wr_rd = 1'b1; d.is_load = 1'b1; end
      ID_SW:   begin d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// rtl/pipe_hazard_ctrl_hazard_scoreboard.sv - EX/MEM/WB destination scoreboard with forwarding compare
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_hold              freeze all three entries (data memory busy)
//   i_bubble            load an invalid entry into EX instead of the ID entry
//   i_id_entry          destination record of the instruction leaving ID
//   i_src_a, i_src_b    ID source registers to compare for forwarding
//   i_mem_load_fwd      allow forwarding a load result from MEM (load data now available)
//   o_sb_ex             current EX entry, used for load-use detection
//   o_fwd_a, o_fwd_b    operand source selects (FWD_RF / FWD_MEM / FWD_WB)
module pipe_hazard_ctrl_hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hold,
  input  logic                i_bubble,
  input  sb_entry_t           i_id_entry,
  input  logic [RegAddrW-1:0] i_src_a,
  input  logic [RegAddrW-1:0] i_src_b,
  input  logic                i_mem_load_fwd,
  output sb_entry_t           o_sb_ex,
  output logic [1:0]          o_fwd_a,
  output logic [1:0]          o_fwd_b
);

  sb_entry_t r_ex, r_mem, r_wb;
  logic      w_unused_wb_load;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!i_hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= i_bubble ? '0 : i_id_entry;
    end
  end

  // WB data is always final, so its load flag is irrelevant for forwarding.
  assign w_unused_wb_load = r_wb.is_load;

  function automatic logic [1:0] fwd_sel(input logic [RegAddrW-1:0] src,
                                         input sb_entry_t mem_e,
                                         input sb_entry_t wb_e,
                                         input logic load_ok);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (mem_e.vld && mem_e.rd == src && (!mem_e.is_load || load_ok))
        sel = FWD_MEM;
      else if (wb_e.vld && wb_e.rd == src)
        sel = FWD_WB;
    end
    return sel;
  endfunction

  assign o_sb_ex = r_ex;
  assign o_fwd_a = fwd_sel(i_src_a, r_mem, r_wb, i_mem_load_fwd);
  assign o_fwd_b = fwd_sel(i_src_b, r_mem, r_wb, i_mem_load_fwd);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RV32 pipeline stall/flush/redirect/forwarding controller
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_id_vld, i_id_instID           ID holds a valid instruction and its decoded ID
//   i_id_rs1, i_id_rs2, i_id_rd     register fields from the decoder
//   i_id_jmp_vld                    JAL in ID (IF already redirected)
//   i_ex_br_taken                   BNE in EX resolved taken
//   i_mem_busy                      data memory not ready, MEM holds
//   o_pc_stall, o_if_id_stall       hold PC / IF-ID register
//   o_if_id_flush, o_id_ex_bubble   squash IF-ID / insert NOP into ID-EX
//   o_redirect_vld                  IF loads the branch target this cycle
//   o_fwd_a, o_fwd_b                operand source selects for rs1 / rs2
//   o_state_dbg                     current FSM state
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int INST_ID_DEPTH = InstIDDepth,
  parameter int REG_ADDR_W    = RegAddrW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_id_vld,
  input  logic [INST_ID_DEPTH-1:0] i_id_instID,
  input  logic [REG_ADDR_W-1:0]    i_id_rs1,
  input  logic [REG_ADDR_W-1:0]    i_id_rs2,
  input  logic [REG_ADDR_W-1:0]    i_id_rd,
  input  logic                     i_id_jmp_vld,
  input  logic                     i_ex_br_taken,
  input  logic                     i_mem_busy,
  output logic                     o_pc_stall,
  output logic                     o_if_id_stall,
  output logic                     o_if_id_flush,
  output logic                     o_id_ex_bubble,
  output logic                     o_redirect_vld,
  output logic [1:0]               o_fwd_a,
  output logic [1:0]               o_fwd_b,
  output logic [1:0]               o_state_dbg
);

  state_e    r_state, w_next;
  dec_t      w_dec;
  sb_entry_t w_id_entry, w_sb_ex;
  logic      w_br, w_jmp, w_lu;
  logic      w_stall, w_flush, w_bubble, w_redir;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_dec = decode(i_id_instID);

  // x0 is never a real destination, so it never enters the scoreboard.
  assign w_id_entry.vld     = i_id_vld && w_dec.wr_rd && (i_id_rd != '0);
  assign w_id_entry.rd      = i_id_rd;
  assign w_id_entry.is_load = w_dec.is_load;

  // After a memory wait EX was frozen and re-raises its branch once running;
  // right after a redirect EX holds a bubble and ID holds a flushed slot.
  assign w_br  = i_ex_br_taken && (r_state == ST_RUN || r_state == ST_LOAD_STALL);
  assign w_jmp = i_id_jmp_vld && (r_state != ST_REDIRECT);

  assign w_lu = i_id_vld && w_sb_ex.vld && w_sb_ex.is_load &&
                ((w_dec.use_rs1 && i_id_rs1 == w_sb_ex.rd) ||
                 (w_dec.use_rs2 && i_id_rs2 == w_sb_ex.rd));

  // Every state resolves through one priority chain; the state only masks
  // events that cannot be genuine in that cycle.
  always_comb begin
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    w_redir  = 1'b0;
    w_next   = ST_RUN;
    if (i_mem_busy) begin
      w_stall = 1'b1;
      w_next  = ST_MEM_WAIT;
    end else if (w_br) begin
      w_redir  = 1'b1;
      w_flush  = 1'b1;
      w_bubble = 1'b1;
      w_next   = ST_REDIRECT;
    end else if (w_lu) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      w_next   = ST_LOAD_STALL;
    end else if (w_jmp) begin
      w_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_next;
  end

  pipe_hazard_ctrl_hazard_scoreboard u_sb (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_hold         (i_mem_busy),
    .i_bubble       (w_bubble),
    .i_id_entry     (w_id_entry),
    .i_src_a        (i_id_rs1),
    .i_src_b        (i_id_rs2),
    .i_mem_load_fwd (r_state == ST_LOAD_STALL),
    .o_sb_ex        (w_sb_ex),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b)
  );

  // Outputs are forced quiet for as long as reset is held.
  assign o_pc_stall     = w_stall  && !i_rst;
  assign o_if_id_stall  = w_stall  && !i_rst;
  assign o_if_id_flush  = w_flush  && !i_rst;
  assign o_id_ex_bubble = w_bubble && !i_rst;
  assign o_redirect_vld = w_redir  && !i_rst;
  assign o_fwd_a        = i_rst ? FWD_RF : w_fwd_a;
  assign o_fwd_b        = i_rst ? FWD_RF : w_fwd_b;
  assign o_state_dbg    = i_rst ? 2'(ST_RUN) : 2'(r_state);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector table plus randomized reference-model check
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_vld, id_jmp_vld, ex_br_taken, mem_busy;
  logic [7:0] id_instID;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, redirect_vld;
  logic [1:0] fwd_a, fwd_b, state_dbg;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_id_vld(id_vld), .i_id_instID(id_instID),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_jmp_vld(id_jmp_vld), .i_ex_br_taken(ex_br_taken), .i_mem_busy(mem_busy),
    .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_if_id_flush(if_id_flush),
    .o_id_ex_bubble(id_ex_bubble), .o_redirect_vld(redirect_vld),
    .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_state_dbg(state_dbg)
  );

  typedef struct {
    bit rst; bit vld; int iid; int rs1; int rs2; int rd; bit jmp; bit br; bit busy;
    bit ps; bit fl; bit bb; bit rv; int fa; int fb; int st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit vl, int iid, int s1, int s2, int d, bit j, bit b, bit bz,
                             bit ps, bit fl, bit bb, bit rv, int fa, int fb, int st);
    vec_t x;
    x = '{r, vl, iid, s1, s2, d, j, b, bz, ps, fl, bb, rv, fa, fb, st};
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit ps, input bit fl, input bit bb,
                           input bit rv, input int fa, input int fb, input int st);
    chk({tag, " pc_stall"}, int'(pc_stall), int'(ps));
    chk({tag, " if_id_stall"}, int'(if_id_stall), int'(ps));
    chk({tag, " if_id_flush"}, int'(if_id_flush), int'(fl));
    chk({tag, " id_ex_bubble"}, int'(id_ex_bubble), int'(bb));
    chk({tag, " redirect_vld"}, int'(redirect_vld), int'(rv));
    chk({tag, " fwd_a"}, int'(fwd_a), fa);
    chk({tag, " fwd_b"}, int'(fwd_b), fb);
    chk({tag, " state_dbg"}, int'(state_dbg), st);
  endtask

  task automatic drive(input bit r, input bit vl, input int iid, input int s1, input int s2,
                       input int d, input bit j, input bit b, input bit bz);
    rst = r; id_vld = vl; id_instID = 8'(iid);
    id_rs1 = 5'(s1); id_rs2 = 5'(s2); id_rd = 5'(d);
    id_jmp_vld = j; ex_br_taken = b; mem_busy = bz;
  endtask

  // Reference model: in-flight destinations EX(0), MEM(1), WB(2) and the
  // kind of cycle the controller is in (0 run, 1 after load stall,
  // 2 waiting on memory, 3 first cycle after a redirect).
  typedef struct { bit w; int rd; bit ld; } stage_t;
  stage_t pipe[3];
  int     m_st;

  function automatic bit reads_rs1(int id);
    return id == int'(ID_ADDI) || id == int'(ID_ADD) || id == int'(ID_BNE) ||
           id == int'(ID_LW) || id == int'(ID_SW);
  endfunction
  function automatic bit reads_rs2(int id);
    return id == int'(ID_ADD) || id == int'(ID_BNE) || id == int'(ID_SW);
  endfunction
  function automatic bit writes_rd(int id);
    return id == int'(ID_ADDI) || id == int'(ID_ADD) || id == int'(ID_LUI) ||
           id == int'(ID_LW) || id == int'(ID_JAL);
  endfunction

  function automatic int fwd_of(int src);
    if (src == 0) return 0;
    if (pipe[1].w && pipe[1].rd == src && (!pipe[1].ld || m_st == 1)) return 1;
    if (pipe[2].w && pipe[2].rd == src) return 2;
    return 0;
  endfunction

  task automatic model_cycle(input vec_t x, output vec_t e);
    bit lu, brk, jk;
    int nst;
    e = x;
    {e.ps, e.fl, e.bb, e.rv} = 4'b0;
    e.fa = 0; e.fb = 0; e.st = 0;
    nst = 0;
    if (!x.rst) begin
      e.st = m_st;
      e.fa = fwd_of(x.rs1);
      e.fb = fwd_of(x.rs2);
      lu  = x.vld && pipe[0].w && pipe[0].ld &&
            ((reads_rs1(x.iid) && x.rs1 == pipe[0].rd) || (reads_rs2(x.iid) && x.rs2 == pipe[0].rd));
      brk = x.br && (m_st == 0 || m_st == 1);
      jk  = x.jmp && m_st != 3;
      if (x.busy)     begin e.ps = 1; nst = 2; end
      else if (brk)   begin e.rv = 1; e.fl = 1; e.bb = 1; nst = 3; end
      else if (lu)    begin e.ps = 1; e.bb = 1; nst = 1; end
      else if (jk)    e.fl = 1;
    end
    // advance the model to the next cycle
    if (x.rst) begin
      foreach (pipe[k]) pipe[k] = '{0, 0, 0};
      m_st = 0;
    end else begin
      if (!x.busy) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (e.bb || !x.vld) pipe[0] = '{0, 0, 0};
        else pipe[0] = '{writes_rd(x.iid) && x.rd != 0, x.rd, x.iid == int'(ID_LW)};
      end
      m_st = nst;
    end
  endtask

  initial begin
    vec_t x, e;
    int   busy_left;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //           rst vld iid  rs1 rs2 rd  jmp br bsy | ps fl bb rv fa fb st
    vecs.push_back(v(1, 0, 0,    0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // load-use: LW x5 then ADD x6,x5,x7
    vecs.push_back(v(0, 1, 6,    1,  0,  5, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    5,  7,  6, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    5,  7,  6, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1));
    // ALU chain: ADDI x3, ADD x4,x3,x3 (producer still in EX), then MEM, then WB
    vecs.push_back(v(0, 1, 1,    0,  0,  3, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    3,  3,  4, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    3,  3,  8, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 1, 2,    3,  4,  9, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0));
    // taken branch together with a load-use hazard
    vecs.push_back(v(0, 1, 6,    0,  0, 10, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,   10,  0, 11, 0, 1, 0,   0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,    0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(v(0, 0, 0,    0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // JAL x1, squashed slot, ADD x2,x1,x0
    vecs.push_back(v(0, 1, 5,    0,  0,  1, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,    0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    1,  0,  2, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0));
    // memory busy for three cycles during an ADD/LW stream
    vecs.push_back(v(0, 1, 6,    2,  0, 12, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    2,  5, 13, 0, 0, 1,   1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 2,    2,  5, 13, 0, 0, 1,   1, 0, 0, 0, 1, 0, 2));
    vecs.push_back(v(0, 1, 2,    2,  5, 13, 0, 0, 1,   1, 0, 0, 0, 1, 0, 2));
    vecs.push_back(v(0, 1, 2,    2,  5, 13, 0, 0, 0,   0, 0, 0, 0, 1, 0, 2));
    vecs.push_back(v(0, 1, 2,   12,  2, 14, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0));
    vecs.push_back(v(0, 1, 2,   12, 13, 15, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0));
    // reset while waiting on memory; no stale forwarding afterwards
    vecs.push_back(v(0, 0, 0,    0,  0,  0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,    0,  0,  0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(v(1, 0, 0,    0,  0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,   15, 14, 16, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,   15, 14, 17, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    // x0 destination never creates a hazard
    vecs.push_back(v(0, 1, 6,    0,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 2,    0,  0,  1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      x = vecs[i];
      drive(x.rst, x.vld, x.iid, x.rs1, x.rs2, x.rd, x.jmp, x.br, x.busy);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), x.ps, x.fl, x.bb, x.rv, x.fa, x.fb, x.st);
      @(posedge clk); #1;
    end

    // randomized run against the reference model, starting from reset
    foreach (pipe[k]) pipe[k] = '{0, 0, 0};
    m_st = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    busy_left = 0;
    for (int c = 0; c < 3000; c++) begin
      x = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      x.rst = ($urandom_range(0, 99) == 0);
      x.vld = ($urandom_range(0, 99) < 85);
      x.iid = $urandom_range(0, 9);
      x.rs1 = $urandom_range(0, 7);
      x.rs2 = $urandom_range(0, 7);
      x.rd  = $urandom_range(0, 7);
      x.jmp = ($urandom_range(0, 9) == 0);
      x.br  = ($urandom_range(0, 9) == 0);
      if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 4);
      x.busy = (busy_left != 0);
      if (busy_left != 0) busy_left--;
      drive(x.rst, x.vld, x.iid, x.rs1, x.rs2, x.rd, x.jmp, x.br, x.busy);
      model_cycle(x, e);
      @(negedge clk);
      check_all($sformatf("rnd%0d", c), e.ps, e.fl, e.bb, e.rv, e.fa, e.fb, e.st);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
